// File: rtl/fp_alu_pkg.sv
// ----------------------------------------------------------------------------
// fp_alu_pkg
// Shared constants and helpers for the FP ALU divider scheduling slice.
//   FP_W / EXP_W / MAN_W : IEEE-754 single-precision field widths
//   QNAN                 : canonical quiet NaN returned for 0/0
//   fp_inf(sign)         : signed infinity encoding
//   sched_state_e        : scheduler FSM state encoding
// ----------------------------------------------------------------------------
package fp_alu_pkg;

    localparam int FP_W  = 32;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_START = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_RESP  = 2'd3
    } sched_state_e;

    function automatic logic [FP_W-1:0] fp_inf(input logic sign);
        return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_div_sched_if.sv
// ----------------------------------------------------------------------------
// fp_div_sched_if
// Bundles the requester channel, the divider operand/result channel and the
// tagged response channel of fp_div_sched.
//   slave  : the scheduler side (drives req_ready, div_*, rsp_*)
//   master : the surrounding logic (drives requests, div_result, rsp_ready)
// Signals:
//   req_valid/req_ready  per-requester handshake, req_ready one-hot or zero
//   req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   div_a/div_b/div_start operands and start pulse to the external divider
//   div_result           divider quotient
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_result/rsp_dz  requester tag, quotient, divide-by-zero flag
// ----------------------------------------------------------------------------
interface fp_div_sched_if #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]       div_a;
    logic [WIDTH-1:0]       div_b;
    logic                   div_start;
    logic [WIDTH-1:0]       div_result;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_dz;

    modport slave (
        input  req_valid, req_a, req_b, div_result, rsp_ready,
        output req_ready, div_a, div_b, div_start,
               rsp_valid, rsp_id, rsp_result, rsp_dz
    );

    modport master (
        output req_valid, req_a, req_b, div_result, rsp_ready,
        input  req_ready, div_a, div_b, div_start,
               rsp_valid, rsp_id, rsp_result, rsp_dz
    );

endinterface

// File: rtl/fp_div_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// ptr_i, wrapping at N_REQ.
//   req_i  : request vector
//   ptr_i  : highest-priority index this cycle
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : binary index of the grant
//   any_o  : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest valid index
    // (lowest offset from the pointer) is the last one written and wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(N_REQ)) begin
                sum = sum - (ID_W + 1)'(N_REQ);
            end
            pos = sum[ID_W-1:0];
            if (req_i[pos]) begin
                gnt_o      = '0;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_div_sched.sv
// ----------------------------------------------------------------------------
// fp_div_sched
// Round-robin scheduler sharing one external floating-point divider among
// N_REQ requesters. One operation is in flight at a time:
//   IDLE  -> grant a requester, latch its operands
//   START -> one-cycle div_start pulse, load the latency counter
//   WAIT  -> count down DIV_LAT cycles, capture div_result
//   RESP  -> present tagged result until rsp_ready
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : fp_div_sched_if.slave (request, divider and response channels)
// Build option:
//   DIV_ZERO_BYPASS_EN : a divisor with zero magnitude skips the divider and
//                        returns +-inf (or QNaN for 0/0) with rsp_dz=1.
//                        Undefined: zero divisors go through the divider and
//                        rsp_dz is tied 0.
// ----------------------------------------------------------------------------
module fp_div_sched
    import fp_alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_REQ   = 4,
    parameter int DIV_LAT = 16
) (
    input  logic             clk,
    input  logic             rst,
    fp_div_sched_if.slave    bus
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

    localparam logic [1:0] S_IDLE  = SCHED_IDLE;
    localparam logic [1:0] S_START = SCHED_START;
    localparam logic [1:0] S_WAIT  = SCHED_WAIT;
    localparam logic [1:0] S_RESP  = SCHED_RESP;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [ID_W-1:0]  id_q,    id_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] res_q,   res_d;
`ifdef DIV_ZERO_BYPASS_EN
    logic             dz_q,    dz_d;
`endif

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
`ifdef DIV_ZERO_BYPASS_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    a_d     = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_d     = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    state_d = S_START;
`ifdef DIV_ZERO_BYPASS_EN
                    dz_d    = (bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH-1] == '0);
`endif
                end
            end
            S_START: begin
`ifdef DIV_ZERO_BYPASS_EN
                if (dz_q) begin
                    // Zero divisor: answer directly without touching the divider.
                    res_d   = (a_q[WIDTH-2:0] == '0) ? QNAN : fp_inf(a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_W'(DIV_LAT - 1);
                    state_d = S_WAIT;
                end
`else
                cnt_d   = CNT_W'(DIV_LAT - 1);
                state_d = S_WAIT;
`endif
            end
            S_WAIT: begin
                // The divider result is valid in the cycle the counter reads zero.
                if (cnt_q == '0) begin
                    res_d   = bus.div_result;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
`ifdef DIV_ZERO_BYPASS_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
`ifdef DIV_ZERO_BYPASS_EN
            dz_q    <= dz_d;
`endif
        end
    end

    // Grant is only visible while idle and out of reset, so nothing is
    // accepted during a reset cycle.
    assign bus.req_ready  = (state_q == S_IDLE && !rst) ? gnt : '0;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;
`ifdef DIV_ZERO_BYPASS_EN
    assign bus.div_start  = (state_q == S_START) && !dz_q;
    assign bus.rsp_dz     = dz_q;
`else
    assign bus.div_start  = (state_q == S_START);
    assign bus.rsp_dz     = 1'b0;
`endif
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;

endmodule
